// File: rtl/decoder_seq_if.sv
// -----------------------------------------------------------------------------
// decoder_seq_if
// Purpose : bundles the select/enable inputs, the sweep request and the
//           registered decoder outputs of decoder_seq into one port.
// Signals :
//   in          [N-1:0]     line select used by normal decode
//   en                      decode enable used by normal decode
//   sweep_start             request a full one-hot sweep (honoured in IDLE)
//   out         [OUTS-1:0]  registered one-hot (or all-zero) select
//   busy                    high while a sweep is running
//   done                    one-cycle pulse while the last line is driven
//   err                     sticky ignored-start flag
//                           (only when DECODER_SEQ_ERR_EN is defined)
// Modports: master drives in/en/sweep_start, slave (the decoder) drives the rest.
// -----------------------------------------------------------------------------
interface decoder_seq_if #(
  parameter int N = 2
);
  localparam int OUTS = 2 ** N;

  logic [N-1:0]    in;
  logic            en;
  logic            sweep_start;
  logic [OUTS-1:0] out;
  logic            busy;
  logic            done;
`ifdef DECODER_SEQ_ERR_EN
  logic            err;

  modport master (output in, en, sweep_start, input out, busy, done, err);
  modport slave  (input in, en, sweep_start, output out, busy, done, err);
`else
  modport master (output in, en, sweep_start, input out, busy, done);
  modport slave  (input in, en, sweep_start, output out, busy, done);
`endif
endinterface

// File: rtl/decoder_seq.sv
// -----------------------------------------------------------------------------
// decoder_seq
// Purpose : registered N-to-2^N one-hot decoder with enable, plus a sweep
//           sequencer that walks the one-hot output across every line, one
//           line per cycle, to initialise or scrub a downstream bank.
// Ports   :
//   clk       single clock, all state changes on its rising edge
//   reset_n   asynchronous active-low reset
//   io_bus    decoder_seq_if.slave (in, en, sweep_start -> out, busy, done[, err])
// Parameters:
//   N     select width, legal 1..6
//   OUTS  output count, derived as 2**N, not to be overridden
// Optional feature:
//   DECODER_SEQ_ERR_EN  when defined, adds the sticky err flag that records a
//                       sweep_start seen while a sweep is already running.
// -----------------------------------------------------------------------------
module decoder_seq #(
  parameter int N    = 2,
  parameter int OUTS = 2 ** N
) (
  input  logic          clk,
  input  logic          reset_n,
  decoder_seq_if.slave  io_bus
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  state_t          r_state, w_state_next;
  logic [N-1:0]    r_idx, w_idx_next, w_idx_inc;
  logic [OUTS-1:0] r_out, w_out_next;
  logic            r_busy, w_busy_next;
  logic            r_done, w_done_next;
  logic            w_last;

  assign w_idx_inc = r_idx + 1'b1;
  // The line currently on out is the final one; the coming edge ends the sweep.
  assign w_last    = (r_state == S_SWEEP) && (r_idx == N'(OUTS - 1));

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_out_next   = r_out;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;

    if (r_state == S_SWEEP && !w_last) begin
      // Mid-sweep: advance one line; sweep_start, in and en are ignored.
      w_idx_next  = w_idx_inc;
      w_out_next  = OUTS'(1) << w_idx_inc;
      w_busy_next = 1'b1;
      w_done_next = (w_idx_inc == N'(OUTS - 1));
    end else if (io_bus.sweep_start) begin
      // Idle, or the terminal edge of a sweep: a held request starts the next
      // sweep immediately so line 0 follows the last line with no gap.
      w_state_next = S_SWEEP;
      w_idx_next   = '0;
      w_out_next   = OUTS'(1);
      w_busy_next  = 1'b1;
    end else begin
      w_state_next = S_IDLE;
      w_idx_next   = '0;
      w_out_next   = io_bus.en ? (OUTS'(1) << io_bus.in) : '0;
      w_busy_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_out   <= w_out_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  assign io_bus.out  = r_out;
  assign io_bus.busy = r_busy;
  assign io_bus.done = r_done;

`ifdef DECODER_SEQ_ERR_EN
  logic r_err;

  // Any request arriving while sweeping (the done cycle included) is recorded
  // until the next reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (r_state == S_SWEEP && io_bus.sweep_start) begin
      r_err <= 1'b1;
    end
  end

  assign io_bus.err = r_err;
`endif

endmodule

// File: tb/tb_decoder_seq.sv
// -----------------------------------------------------------------------------
// tb_decoder_seq
// Purpose : self-checking bench for decoder_seq with one N=2 and one N=3
//           instance sharing clock and reset. A timing-based reference model
//           predicts out/busy/done/err every cycle; directed scenarios pin the
//           model with literal expectations; random traffic follows.
// -----------------------------------------------------------------------------
module tb_decoder_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] in2 = '0;
  logic [2:0] in3 = '0;
  logic       en2 = 1'b0, en3 = 1'b0, ss2 = 1'b0, ss3 = 1'b0;

  decoder_seq_if #(.N(2)) bus2();
  decoder_seq_if #(.N(3)) bus3();

  assign bus2.in = in2;
  assign bus2.en = en2;
  assign bus2.sweep_start = ss2;
  assign bus3.in = in3;
  assign bus3.en = en3;
  assign bus3.sweep_start = ss3;

  decoder_seq #(.N(2)) dut2 (.clk(clk), .reset_n(reset_n), .io_bus(bus2));
  decoder_seq #(.N(3)) dut3 (.clk(clk), .reset_n(reset_n), .io_bus(bus3));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A sweep accepted at edge s drives line (e - s) after edge e, for
  // e - s in 0..OUTS-1; otherwise the output is the decode of in/en.
  int          outs_of [2] = '{4, 8};
  int          start_edge [2];
  int          edge_no;
  logic [63:0] exp_out [2];
  logic        exp_busy [2];
  logic        exp_done [2];
  logic        exp_err [2];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_no = 0;
      for (int k = 0; k < 2; k++) begin
        start_edge[k] = -1;
        exp_out[k]    = '0;
        exp_busy[k]   = 1'b0;
        exp_done[k]   = 1'b0;
        exp_err[k]    = 1'b0;
      end
    end else begin
      edge_no++;
      for (int k = 0; k < 2; k++) begin
        logic s_req, s_en;
        int   sel, d;
        s_req = (k == 0) ? ss2 : ss3;
        s_en  = (k == 0) ? en2 : en3;
        sel   = (k == 0) ? int'(in2) : int'(in3);
        d     = edge_no - start_edge[k];
        if (s_req && exp_busy[k]) exp_err[k] = 1'b1;
        if (start_edge[k] >= 0 && d >= 1 && d <= outs_of[k] - 1) begin
          exp_out[k]  = 64'd1 << d;
          exp_busy[k] = 1'b1;
          exp_done[k] = (d == outs_of[k] - 1);
        end else if (s_req) begin
          start_edge[k] = edge_no;
          exp_out[k]    = 64'd1;
          exp_busy[k]   = 1'b1;
          exp_done[k]   = 1'b0;
        end else begin
          start_edge[k] = -1;
          exp_out[k]    = s_en ? (64'd1 << sel) : 64'd0;
          exp_busy[k]   = 1'b0;
          exp_done[k]   = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      chk("out2",    64'(bus2.out),  exp_out[0]);
      chk("busy2",   64'(bus2.busy), 64'(exp_busy[0]));
      chk("done2",   64'(bus2.done), 64'(exp_done[0]));
      chk("onehot2", 64'($countones(bus2.out) <= 1), 64'd1);
      chk("out3",    64'(bus3.out),  exp_out[1]);
      chk("busy3",   64'(bus3.busy), 64'(exp_busy[1]));
      chk("done3",   64'(bus3.done), 64'(exp_done[1]));
      chk("onehot3", 64'($countones(bus3.out) <= 1), 64'd1);
`ifdef DECODER_SEQ_ERR_EN
      chk("err2",    64'(bus2.err),  64'(exp_err[0]));
      chk("err3",    64'(bus3.err),  64'(exp_err[1]));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus + literal checks ----------------
  initial begin
    repeat (2) step();
    chk("rst_out2",  64'(bus2.out),  64'd0);
    chk("rst_busy2", 64'(bus2.busy), 64'd0);
    chk("rst_done3", 64'(bus3.done), 64'd0);
    reset_n = 1'b1;

    // Normal decode, one cycle latency.
    $display("phase: decode N=2");
    en2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in2 = 2'(i);
      step();
      chk("dec2", 64'(bus2.out), 64'd1 << i);
    end
    en2 = 1'b0;
    step();
    chk("dec2_dis", 64'(bus2.out), 64'd0);

    // Single sweep on N=2, then decode of in=2.
    $display("phase: single sweep N=2");
    in2 = 2'd2; en2 = 1'b1; ss2 = 1'b1;
    step();
    ss2 = 1'b0;
    chk("sw2_out0",  64'(bus2.out),  64'd1);
    chk("sw2_busy0", 64'(bus2.busy), 64'd1);
    chk("sw2_done0", 64'(bus2.done), 64'd0);
    for (int k = 1; k < 4; k++) begin
      step();
      chk("sw2_out",  64'(bus2.out),  64'd1 << k);
      chk("sw2_busy", 64'(bus2.busy), 64'd1);
      chk("sw2_done", 64'(bus2.done), 64'(k == 3));
    end
    step();
    chk("sw2_after_out",  64'(bus2.out),  64'b0100);
    chk("sw2_after_busy", 64'(bus2.busy), 64'd0);
    chk("sw2_after_done", 64'(bus2.done), 64'd0);

    // Held request on N=3: back-to-back sweeps with no gap.
    $display("phase: held sweep N=3");
    ss3 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("hold3_out",  64'(bus3.out),  64'd1 << ((i - 1) % 8));
      chk("hold3_done", 64'(bus3.done), 64'(i == 8 || i == 16));
    end
    ss3 = 1'b0;
    for (int c = 0; c < 20 && bus3.busy; c++) step();
    chk("hold3_end_busy", 64'(bus3.busy), 64'd0);

    // Asynchronous reset while N=2 shows line 2.
    $display("phase: async reset mid-sweep");
    ss2 = 1'b1;
    step();
    ss2 = 1'b0;
    step();
    step();
    chk("pre_rst_out2", 64'(bus2.out), 64'b0100);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_out2",  64'(bus2.out),  64'd0);
    chk("arst_busy2", 64'(bus2.busy), 64'd0);
    chk("arst_done2", 64'(bus2.done), 64'd0);
    step();
    reset_n = 1'b1;
    in2 = 2'd1; en2 = 1'b1;
    step();
    chk("post_rst_dec2", 64'(bus2.out), 64'b0010);

`ifdef DECODER_SEQ_ERR_EN
    // Ignored request during an N=3 sweep sets err and leaves the sweep intact.
    $display("phase: ignored start N=3");
    ss3 = 1'b1;
    step();
    ss3 = 1'b0;
    step();
    step();
    chk("err3_before", 64'(bus3.err), 64'd0);
    ss3 = 1'b1;
    step();
    ss3 = 1'b0;
    chk("err3_line3", 64'(bus3.out), 64'd1 << 3);
    chk("err3_set",   64'(bus3.err), 64'd1);
    for (int k = 4; k < 8; k++) begin
      step();
      chk("err3_line", 64'(bus3.out), 64'd1 << k);
    end
    repeat (3) step();
    chk("err3_sticky", 64'(bus3.err), 64'd1);
`endif

    // Random traffic checked by the per-cycle model compare.
    $display("phase: random 1000 cycles");
    for (int i = 0; i < 1000; i++) begin
      ss2 = ($urandom_range(0, 15) == 0);
      ss3 = ($urandom_range(0, 15) == 0);
      en2 = 1'($urandom);
      en3 = 1'($urandom);
      in2 = 2'($urandom);
      in3 = 3'($urandom);
      step();
    end
    ss2 = 1'b0;
    ss3 = 1'b0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
